// File: rtl/dp_idle_pkg.sv
// Shared definitions for the multi-lane idle pattern generator: Gray-coded
// state encoding, control symbol constants and lane-count normalisation.
package dp_idle_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        BS1   = 4'b0001,
        BS2   = 4'b0011,
        BS3   = 4'b0010,
        BS4   = 4'b0110,
        VBID  = 4'b0111,
        MVID  = 4'b0101,
        MAUD  = 4'b0100,
        DUMMY = 4'b1100
    } idle_state_e;

    localparam logic [7:0] SYM_BS    = 8'hBC;
    localparam logic [7:0] SYM_BF    = 8'hBD;
    localparam logic [7:0] SYM_SR    = 8'h1C;
    localparam logic [7:0] SYM_DUMMY = 8'h00;

    // Anything other than a legal count that fits the physical lanes runs one lane.
    function automatic logic [2:0] lane_count_norm(input logic [2:0] cfg, input int lanes);
        logic [2:0] n;
        n = 3'd1;
        case (cfg)
            3'd2:    n = (lanes >= 2) ? 3'd2 : 3'd1;
            3'd4:    n = (lanes >= 4) ? 3'd4 : 3'd1;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/idle_pattern_mlane_lane_mux.sv
// Fans the single idle symbol/control flag out to the physical lanes; lanes at
// or above the active count are forced to 8'h00 with their flag low.
module idle_lane_mux
    import dp_idle_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [7:0]         sym,
    input  logic               ctrl,
    input  logic [2:0]         lane_count,
    output logic [8*LANES-1:0] lane_sym,
    output logic [LANES-1:0]   lane_ctrl
);

    logic [2:0] active_n;

    assign active_n = lane_count_norm(lane_count, LANES);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic lane_on;
            assign lane_on             = (3'(gi) < active_n);
            assign lane_sym[8*gi +: 8] = lane_on ? sym : 8'h00;
            assign lane_ctrl[gi]       = lane_on & ctrl;
        end
    endgenerate

endmodule

// File: rtl/idle_pattern_mlane.sv
// Multi-lane idle pattern generator (BS,BF,BF,BS,VBID,MVID,MAUD,DUMMY...).
// Define IDLE_SR_INSERT_EN to replace BS with SR on every SR_INTERVAL-th pattern.
module idle_pattern_mlane
    import dp_idle_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PERIOD      = 8192,
    parameter int SR_INTERVAL = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sched_idle_en,
    input  logic [2:0]         cfg_lane_count,
    input  logic [7:0]         vbid_in,
    input  logic [7:0]         mvid_in,
    input  logic [7:0]         maud_in,
    output logic [8*LANES-1:0] idle_symbols,
    output logic [LANES-1:0]   idle_control_sym_flag,
    output logic               idle_activate_en,
    output logic               idle_sr_flag
);

    localparam int             CW       = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    idle_state_e   state_q, state_d;
    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]    lanes_q;
    logic [7:0]    vbid_q, mvid_q, maud_q;
    logic          last_dummy;
    logic          sr_pattern;

    assign last_dummy = (state_q == DUMMY) && (sym_cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q + 1'b1;
        if (!sched_idle_en) begin
            state_d   = IDLE;
            sym_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE:  begin state_d = BS1; sym_cnt_d = '0; end
                BS1:   state_d = BS2;
                BS2:   state_d = BS3;
                BS3:   state_d = BS4;
                BS4:   state_d = VBID;
                VBID:  state_d = MVID;
                MVID:  state_d = MAUD;
                MAUD:  state_d = DUMMY;
                DUMMY: begin
                    if (last_dummy) begin
                        state_d   = BS1;
                        sym_cnt_d = '0;
                    end
                end
                default: begin state_d = IDLE; sym_cnt_d = '0; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sym_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

`ifdef IDLE_SR_INSERT_EN
    localparam int            SW      = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;
    localparam logic [SW-1:0] SR_LAST = SW'(SR_INTERVAL - 1);

    logic [SW-1:0] sr_cnt_q, sr_cnt_d;

    // The count indexes the pattern in flight; it only advances on DUMMY->BS1.
    always_comb begin
        sr_cnt_d = sr_cnt_q;
        if (!sched_idle_en) begin
            sr_cnt_d = '0;
        end else if (last_dummy) begin
            sr_cnt_d = (sr_cnt_q == SR_LAST) ? '0 : sr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_cnt_q <= '0;
        end else begin
            sr_cnt_q <= sr_cnt_d;
        end
    end

    assign sr_pattern = (sr_cnt_q == '0);
`else
    assign sr_pattern = 1'b0;
`endif

    // Pattern inputs are sampled during BS1 and held for the rest of the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= 3'd1;
            vbid_q  <= 8'h00;
            mvid_q  <= 8'h00;
            maud_q  <= 8'h00;
        end else if (state_q == BS1) begin
            lanes_q <= cfg_lane_count;
            vbid_q  <= vbid_in;
            mvid_q  <= mvid_in;
            maud_q  <= maud_in;
        end
    end

    logic [7:0] sym_c;
    logic       ctrl_c;
    logic       act_c;
    logic       sr_c;
    logic [2:0] lanes_eff;

    always_comb begin
        sym_c  = SYM_DUMMY;
        ctrl_c = 1'b0;
        act_c  = 1'b0;
        sr_c   = 1'b0;
        case (state_q)
            BS1: begin
                sym_c  = sr_pattern ? SYM_SR : SYM_BS;
                ctrl_c = 1'b1;
                sr_c   = sr_pattern;
            end
            BS2, BS3: begin
                sym_c  = SYM_BF;
                ctrl_c = 1'b1;
            end
            BS4: begin
                sym_c  = sr_pattern ? SYM_SR : SYM_BS;
                ctrl_c = 1'b1;
                sr_c   = sr_pattern;
                act_c  = 1'b1;
            end
            VBID: begin sym_c = vbid_q; act_c = 1'b1; end
            MVID: begin sym_c = mvid_q; act_c = 1'b1; end
            MAUD: begin sym_c = maud_q; act_c = 1'b1; end
            DUMMY: act_c = !last_dummy;
            default: begin end
        endcase
    end

    // BS1 already emits with the lane count being latched in that same cycle.
    assign lanes_eff = (state_q == BS1) ? cfg_lane_count : lanes_q;

    logic [8*LANES-1:0] lane_sym_c;
    logic [LANES-1:0]   lane_ctrl_c;

    idle_lane_mux #(
        .LANES (LANES)
    ) u_lane_mux (
        .sym        (sym_c),
        .ctrl       (ctrl_c),
        .lane_count (lanes_eff),
        .lane_sym   (lane_sym_c),
        .lane_ctrl  (lane_ctrl_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_symbols          <= '0;
            idle_control_sym_flag <= '0;
            idle_activate_en      <= 1'b0;
            idle_sr_flag          <= 1'b0;
        end else begin
            idle_symbols          <= lane_sym_c;
            idle_control_sym_flag <= lane_ctrl_c;
            idle_activate_en      <= act_c;
            idle_sr_flag          <= sr_c;
        end
    end

endmodule
